// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - start/busy/done operand and result bundle for nibble_serial_adder
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryInput;
  logic             subtract;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryOutput;
  logic             overflow;

  modport master (
    output start, a, b, carryInput, subtract,
    input  busy, done, sum, carryOutput, overflow
  );

  modport slave (
    input  start, a, b, carryInput, subtract,
    output busy, done, sum, carryOutput, overflow
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit add/sub iterating one 4-bit carry-lookahead slice, LS nibble first
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_sum;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_msb_a;
  logic             r_msb_b;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_c;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_ovf_next;

  // cla4 slice: generate/propagate lookahead over the current operand nibble
  assign w_g    = r_op_a[3:0] & r_op_b[3:0];
  assign w_p    = r_op_a[3:0] ^ r_op_b[3:0];
  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_slice_sum  = w_p ^ w_c[3:0];
  assign w_slice_cout = w_c[4];

  // New nibble enters at the top; after N cycles nibble 0 has reached bit 0
  assign w_shift_next = WIDTH'({w_slice_sum, r_shift} >> 4);
  assign w_ovf_next   = (r_msb_a == r_msb_b) && (w_shift_next[WIDTH-1] != r_msb_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_shift <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_msb_a <= 1'b0;
      r_msb_b <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op_a  <= bus.a;
            r_op_b  <= bus.subtract ? ~bus.b : bus.b;
            r_carry <= bus.subtract ? 1'b1 : bus.carryInput;
            r_msb_a <= bus.a[WIDTH-1];
            r_msb_b <= bus.subtract ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_op_a  <= r_op_a >> 4;
          r_op_b  <= r_op_b >> 4;
          r_shift <= w_shift_next;
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_sum   <= w_shift_next;
            r_cout  <= w_slice_cout;
            r_ovf   <= w_ovf_next;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.sum         = r_sum;
  assign bus.carryOutput = r_cout;
  assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed vector table plus handshake/reset sequences for nibble_serial_adder
module tb_nibble_serial_adder;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  logic [15:0] last_sum;
  vec_t tbl[10];

  nibble_serial_adder_if #(.WIDTH(16)) bus ();

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.a = v.a; bus.b = v.b; bus.carryInput = v.cin; bus.subtract = v.sub; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    // scramble inputs after the accept edge; result must not move
    bus.a = ~v.a; bus.b = v.b ^ 16'h5a5a; bus.carryInput = ~v.cin; bus.subtract = ~v.sub;
    lat = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cnt++;
      chk({tag, "_sum_stable"}, bus.sum, last_sum);
      @(negedge clk);
      lat++;
    end
    if (bus.busy) busy_cnt++;
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_busy_cycles"}, busy_cnt, 5);
    chk({tag, "_sum"}, bus.sum, v.s);
    chk({tag, "_cout"}, bus.carryOutput, v.co);
    chk({tag, "_ovf"}, bus.overflow, v.ov);
    @(negedge clk);
    chk({tag, "_done_pulse"}, bus.done, 1'b0);
    chk({tag, "_idle"}, bus.busy, 1'b0);
    chk({tag, "_sum_hold"}, bus.sum, v.s);
    last_sum = v.s;
  endtask

  function automatic logic [15:0] hold_a(input int c);
    return 16'h0F00 + 16'(c * 16'h1111);
  endfunction

  function automatic logic [15:0] hold_b(input int c);
    return 16'h00F0 ^ 16'(c * 16'h0303);
  endfunction

  initial begin
    logic [16:0] full;
    int wait_cnt;
    int done_cnt;
    n_vec = 0;
    n_bad = 0;
    last_sum = 16'h0000;
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[9] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.carryInput = 1'b0; bus.subtract = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_sum", bus.sum, 16'h0000);
    chk("rst_cout", bus.carryOutput, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // start pulsed during RUN must be dropped, not queued
    @(negedge clk);
    bus.a = 16'h1111; bus.b = 16'h2222; bus.carryInput = 1'b0; bus.subtract = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cnt = 0;
    while (!bus.done && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
    chk("pulse_done_seen", bus.done, 1'b1);
    chk("pulse_sum", bus.sum, 16'h3333);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("pulse_not_queued", bus.busy, 1'b0);
    end
    last_sum = 16'h3333;

    // start held high: accepts every 6 cycles with the operands present at each accept edge
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk($sformatf("hold_done_c%0d", c), bus.done, (c % 6) == 5);
        if ((c % 6) == 5) begin
          full = {1'b0, hold_a(c - 5)} + {1'b0, hold_b(c - 5)};
          chk($sformatf("hold_sum_c%0d", c), bus.sum, full[15:0]);
          chk($sformatf("hold_cout_c%0d", c), bus.carryOutput, full[16]);
          last_sum = full[15:0];
        end
      end
      bus.a = hold_a(c); bus.b = hold_b(c); bus.carryInput = 1'b0; bus.subtract = 1'b0;
      bus.start = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("hold_stop_idle", bus.busy, 1'b0);

    // reset between T2 and T3 clears outputs without a clock edge
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h1111; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("prerst_busy", bus.busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_sum", bus.sum, 16'h0000);
    chk("midrst_cout", bus.carryOutput, 1'b0);
    chk("midrst_ovf", bus.overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    last_sum = 16'h0000;
    run_vec(tbl[9], "postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
